adc_rx: RTL and testbench
=========================

ADC_RX -- requirements
Module: adc_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width and bits captured per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, sample buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cs  input  1  ADC chip select from the ADC SPI controller, active-low, clk-synchronous.
REQ-006 SHALL have port sdo  input  1  ADC serial data, MSB first, valid at clk rising edge while cs low.
REQ-007 SHALL have port m_data  output  DATA_W  head-of-buffer sample.
REQ-008 SHALL have port m_valid  output  1  buffer non-empty.
REQ-009 SHALL have port m_ready  input  1  consumer accepts; transfer when m_valid && m_ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: frame ended with fewer than DATA_W bits.
REQ-011 SHALL have port ovf  output  1  one-cycle pulse: complete sample dropped because buffer full.

Function
REQ-012 SHALL implement FSM IDLE -> SHIFT when cs==0; SHIFT -> DONE when cs==1; DONE -> SHIFT if cs==0 else IDLE.
REQ-013 SHALL, on each clk edge in SHIFT with cs==0 and bit_cnt<DATA_W, shift sdo into LSB of shift register and increment bit_cnt.
REQ-014 SHALL saturate bit_cnt at DATA_W; bits beyond DATA_W ignored (e.g. 100-cycle acquisition keeps first 16 bits).
REQ-015 SHALL also capture sdo on the IDLE->SHIFT edge (first cs==0 cycle is bit DATA_W-1).
REQ-016 SHALL, in DONE, push shift register if bit_cnt==DATA_W, else pulse frame_err; bit_cnt cleared on leaving DONE.
REQ-017 SHALL make a pushed sample visible on m_valid/m_data the cycle after DONE (latency: 2 clk after cs rises).
REQ-018 SHALL, on push with buffer full and no simultaneous pop, drop the new sample and pulse ovf; buffer contents unchanged.
REQ-019 SHALL, on push and pop in same cycle when full, perform both; no ovf.
REQ-020 SHALL ignore m_ready when m_valid==0; m_data don't-care when empty.
REQ-021 SHALL deliver samples in FIFO order; m_data stable while m_valid && !m_ready.
REQ-022 SHALL treat zero-length frames (cs low for 0 cycles) as no event.

Reset
REQ-023 SHALL on rst: FSM IDLE, bit_cnt 0, shift register 0, buffer empty, m_valid 0, m_data 0, frame_err 0, ovf 0.
REQ-024 SHALL discard any partial frame on rst mid-SHIFT; after rst release with cs already low, capture restarts at bit DATA_W-1 (frame counted short unless DATA_W bits follow).

Configuration
REQ-025 SHALL, with ADC_RX_CNT_EN defined, add output sample_cnt[15:0]: increments on every successful push, wraps 0xFFFF->0, resets to 0.
REQ-026 SHALL, without ADC_RX_CNT_EN, have no sample_cnt port and no counter logic.

Structure
REQ-027 SHALL place FSM state encodings and DATA_W/FIFO_DEPTH defaults in shared package adc_pkg.
REQ-028 SHALL implement the buffer as sub-module adc_rx_fifo (sync FIFO, full/empty flags, simultaneous rd/wr).

Verification
REQ-029 SHALL verify: cs low 16 cycles, sdo = 0xA5C3 MSB first -> one m_valid beat, m_data=0xA5C3, 2 clk after cs high.
REQ-030 SHALL verify: cs low 100 cycles, first 16 bits 0x1234 then ones -> m_data=0x1234, no frame_err.
REQ-031 SHALL verify: cs low 10 cycles -> frame_err one-cycle pulse, m_valid stays 0.
REQ-032 SHALL verify: m_ready=0, five frames 0x0001..0x0005 -> ovf on fifth; then m_ready=1 reads 0x0001..0x0004 in order.
REQ-033 SHALL verify: rst asserted after 8 bits of a frame -> all outputs reset, no push, next full frame 0xBEEF received correctly.
REQ-034 SHALL verify: buffer full, m_ready=1 during DONE of frame 0x00FF -> no ovf, 0x00FF delivered last.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC serial receiver.
// Holds FSM state encodings and default DATA_W / FIFO_DEPTH.
package adc_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/adc_rx_if.sv
// Valid/ready sample stream bundle.
// master drives data/valid and reads ready; slave the reverse.
interface adc_rx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/adc_rx_fifo.sv
// Synchronous sample FIFO with full/empty and same-cycle rd/wr.
// Ports: clk, rst, wr_en, wr_data, full; m = output stream (head entry).
module adc_rx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  adc_rx_if.master          m
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              empty;
  logic              rd_en;

  // Extra MSB on the pointers tells full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en = m.valid && m.ready;

  assign m.valid = !empty;
  assign m.data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/adc_rx.sv
// ADC serial receiver: deserialises sdo while cs is low, buffers samples.
// Ports: clk, rst, cs, sdo in; m_data/m_valid/m_ready stream; frame_err, ovf
// pulses; sample_cnt only when ADC_RX_CNT_EN is defined.
module adc_rx
  import adc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sdo,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic              ovf
`ifdef ADC_RX_CNT_EN
  ,
  output logic [15:0]       sample_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              frame_err_q, frame_err_d;
  logic              ovf_q, ovf_d;
  logic              push, full, pop, wr_en;

  adc_rx_if #(.DATA_W(DATA_W)) buf_if ();

  assign buf_if.ready = m_ready;
  assign m_data       = buf_if.data;
  assign m_valid      = buf_if.valid;
  assign pop          = m_valid && m_ready;
  // A full buffer still accepts when the head leaves this cycle.
  assign wr_en        = push && (!full || pop);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    ovf_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!cs) begin
          state_d   = ST_SHIFT;
          shreg_d   = {shreg_q[DATA_W-2:0], sdo};
          bit_cnt_d = CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cs) begin
          state_d = ST_DONE;
        end else if (bit_cnt_q < CNT_W'(DATA_W)) begin
          shreg_d   = {shreg_q[DATA_W-2:0], sdo};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        push        = (bit_cnt_q == CNT_W'(DATA_W));
        frame_err_d = !push;
        ovf_d       = push && full && !pop;
        bit_cnt_d   = '0;
        state_d     = ST_IDLE;
        // cs already low again: this edge carries the next frame's MSB.
        if (!cs) begin
          state_d   = ST_SHIFT;
          shreg_d   = {shreg_q[DATA_W-2:0], sdo};
          bit_cnt_d = CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign frame_err = frame_err_q;
  assign ovf       = ovf_q;

  adc_rx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(shreg_q),
    .full   (full),
    .m      (buf_if.master)
  );

`ifdef ADC_RX_CNT_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    if (wr_en) sample_cnt_d = sample_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_cnt_q <= '0;
    else     sample_cnt_q <= sample_cnt_d;
  end

  assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_adc_rx.sv
// Directed self-checking bench for adc_rx.
// Drives at negedge, samples at negedge (away from the rising edge).
module tb_adc_rx;

  logic clk = 1'b0;
  logic rst;
  logic cs;
  logic sdo;
  logic frame_err;
  logic ovf;
  int   n_cmp = 0;
  int   n_bad = 0;

  adc_rx_if #(.DATA_W(16)) mon ();

  always #5 clk = ~clk;

  adc_rx dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .sdo      (sdo),
    .m_data   (mon.data),
    .m_valid  (mon.valid),
    .m_ready  (mon.ready),
    .frame_err(frame_err),
    .ovf      (ovf)
  );

  // Shift nbits with cs low, MSB first, then raise cs at a negedge.
  task automatic frame(input logic [15:0] val, input int nbits,
                       input logic fill);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      cs  = 1'b0;
      sdo = (i < 16) ? val[15-i] : fill;
    end
    @(negedge clk);
    cs  = 1'b1;
    sdo = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs = 1'b1;
    sdo = 1'b0;
    mon.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mon.valid, mon.data, frame_err, ovf} !== 19'd0) begin
      $display("FAIL reset_outputs act=%h req=0",
               {mon.valid, mon.data, frame_err, ovf});
      n_bad++;
    end
  endtask

  task automatic test_basic();
    frame(16'hA5C3, 16, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b0) begin
      $display("FAIL basic_early act=%b req=0", mon.valid);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b1 || mon.data !== 16'hA5C3) begin
      $display("FAIL basic_data act=%b/%h req=1/a5c3",
               mon.valid, mon.data);
      n_bad++;
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      $display("FAIL basic_ferr act=%b req=0", frame_err);
      n_bad++;
    end
    mon.ready = 1'b1;
    @(negedge clk);
    mon.ready = 1'b0;
    n_cmp++;
    if (mon.valid !== 1'b0) begin
      $display("FAIL basic_one_beat act=%b req=0", mon.valid);
      n_bad++;
    end
  endtask

  task automatic test_long();
    frame(16'h1234, 100, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b1 || mon.data !== 16'h1234 ||
        frame_err !== 1'b0) begin
      $display("FAIL long_frame act=%b/%h/%b req=1/1234/0",
               mon.valid, mon.data, frame_err);
      n_bad++;
    end
    mon.ready = 1'b1;
    @(negedge clk);
    mon.ready = 1'b0;
  endtask

  task automatic test_short();
    frame(16'hFFFF, 10, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      $display("FAIL short_early act=%b req=0", frame_err);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (frame_err !== 1'b1 || mon.valid !== 1'b0) begin
      $display("FAIL short_pulse act=%b/%b req=1/0",
               frame_err, mon.valid);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (frame_err !== 1'b0 || mon.valid !== 1'b0) begin
      $display("FAIL short_end act=%b/%b req=0/0",
               frame_err, mon.valid);
      n_bad++;
    end
  endtask

  task automatic test_overflow();
    mon.ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      frame(16'(k), 16, 1'b0);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (ovf !== (k == 5)) begin
        $display("FAIL ovf_frame%0d act=%b req=%b", k, ovf, k == 5);
        n_bad++;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b0) begin
      $display("FAIL ovf_pulse_end act=%b req=0", ovf);
      n_bad++;
    end
    mon.ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (mon.valid !== 1'b1 || mon.data !== 16'(k)) begin
        $display("FAIL ovf_read%0d act=%b/%h req=1/%h",
                 k, mon.valid, mon.data, 16'(k));
        n_bad++;
      end
      @(negedge clk);
    end
    mon.ready = 1'b0;
    n_cmp++;
    if (mon.valid !== 1'b0) begin
      $display("FAIL ovf_drained act=%b req=0", mon.valid);
      n_bad++;
    end
  endtask

  task automatic test_rst_mid();
    frame(16'h7777, 16, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cs  = 1'b0;
      sdo = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mon.valid, mon.data, frame_err, ovf} !== 19'd0) begin
      $display("FAIL rst_mid_outputs act=%h req=0",
               {mon.valid, mon.data, frame_err, ovf});
      n_bad++;
    end
    @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b0 || frame_err !== 1'b0) begin
      $display("FAIL rst_no_push act=%b/%b req=0/0",
               mon.valid, frame_err);
      n_bad++;
    end
    frame(16'hBEEF, 16, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b1 || mon.data !== 16'hBEEF) begin
      $display("FAIL rst_next_frame act=%b/%h req=1/beef",
               mon.valid, mon.data);
      n_bad++;
    end
    mon.ready = 1'b1;
    @(negedge clk);
    mon.ready = 1'b0;
    n_cmp++;
    if (mon.valid !== 1'b0) begin
      $display("FAIL rst_single act=%b req=0", mon.valid);
      n_bad++;
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] exp_q [5];
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h00FF};
    mon.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      frame(exp_q[k], 16, 1'b0);
      repeat (2) @(negedge clk);
    end
    frame(16'h00FF, 16, 1'b0);
    @(negedge clk);
    mon.ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b0) begin
      $display("FAIL fullpop_ovf act=%b req=0", ovf);
      n_bad++;
    end
    for (int k = 1; k < 5; k++) begin
      n_cmp++;
      if (mon.valid !== 1'b1 || mon.data !== exp_q[k]) begin
        $display("FAIL fullpop_read%0d act=%b/%h req=1/%h",
                 k, mon.valid, mon.data, exp_q[k]);
        n_bad++;
      end
      @(negedge clk);
    end
    mon.ready = 1'b0;
    n_cmp++;
    if (mon.valid !== 1'b0) begin
      $display("FAIL fullpop_drained act=%b req=0", mon.valid);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    mon.ready = 1'b0;
    frame(16'h1111, 16, 1'b0);
    frame(16'h2222, 16, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b1 || mon.data !== 16'h1111 ||
        frame_err !== 1'b0) begin
      $display("FAIL b2b_first act=%b/%h/%b req=1/1111/0",
               mon.valid, mon.data, frame_err);
      n_bad++;
    end
    mon.ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b1 || mon.data !== 16'h2222) begin
      $display("FAIL b2b_second act=%b/%h req=1/2222",
               mon.valid, mon.data);
      n_bad++;
    end
    @(negedge clk);
    mon.ready = 1'b0;
    n_cmp++;
    if (mon.valid !== 1'b0) begin
      $display("FAIL b2b_drained act=%b req=0", mon.valid);
      n_bad++;
    end
  endtask

  task automatic test_idle_no_event();
    cs = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (mon.valid !== 1'b0 || frame_err !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL idle_quiet act=%b/%b/%b req=0/0/0",
               mon.valid, frame_err, ovf);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_no_event();
    test_basic();
    test_long();
    test_short();
    test_overflow();
    test_rst_mid();
    test_full_pop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
